uart_loader: RTL
================

// Module: uart_loader
// PURPOSE
//  Serial program loader upstream of programrom and dmemory32. Receives framed bytes on
//  upg_rx_i, assembles little-endian 32-bit words and drives the upg_* write port. Bit 14
//  of upg_adr_o selects the target: 0 = instruction ROM, 1 = data RAM.
//  Raises upg_done_o when the host ends the session; the CPU leaves upg reset after that.
// PARAMETERS
//  CLK_HZ     10_000_000  frequency of clock (upg clock domain)
//  BAUD       115_200     serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, truncated (86)
//  MAX_WORDS  16384       words per target; word index is 14 bits
// PORTS
//  clock       in   1   single clock; every register samples on its rising edge
//  reset       in   1   synchronous, active-high; clears all state
//  upg_rx_i    in   1   asynchronous serial line, 8N1, idle high
//  upg_wen_o   out  1   one-cycle write strobe
//  upg_adr_o   out  15  {target, word_index[13:0]}
//  upg_dat_o   out  32  assembled word; valid while upg_wen_o=1
//  upg_done_o  out  1   session finished; sticky until reset
//  upg_err_o   out  1   sticky: framing error or bad command seen
// BEHAVIOUR
//  Reset values: upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, upg_err_o=0.
//  State after reset: FSM=IDLE.
//  Byte receiver (uart_rx):
//   - 2-FF synchronizer on upg_rx_i.
//   - Start is a falling edge. It is re-checked low at CLKS_PER_BIT/2; if high, it is a
//     glitch and is discarded.
//   - Data bits are sampled every CLKS_PER_BIT after that point, LSB first.
//   - Stop bit is sampled the same way. If it is 0, no byte is produced, err is set and
//     the receiver waits for the line to go high.
//   - byte_valid is a 1-cycle pulse with byte_data, issued in the stop-sample cycle.
//  Frame formats:
//   - Load: CMD, CNT_LO, CNT_HI, then CNT*4 data bytes, little-endian per word.
//   - End: the single byte 0x45 ('E').
//   - CMD 0x49 ('I') sets target=0; CMD 0x44 ('D') sets target=1.
//  FSM states: IDLE, CNT_LO, CNT_HI, DATA, DONE.
//   - IDLE: 'I'/'D' -> CNT_LO and latch target. 'E' -> DONE.
//     Any other byte: set err, stay in IDLE.
//   - CNT_LO -> CNT_HI -> DATA. count is 16 bits. count=0 -> IDLE.
//     count>MAX_WORDS is clamped to MAX_WORDS.
//   - DATA: byte lane = byte_idx[1:0]; byte_idx resets to 0 on entry.
//     - The 4th byte registers the word and pulses upg_wen_o on the next cycle.
//     - In that cycle, upg_adr_o = {target, word_index}.
//     - word_index starts at 0 per frame and increments after each strobe.
//     - After count strobes -> IDLE.
//   - DONE: upg_done_o=1, all bytes ignored, upg_wen_o stays 0.
//  Latency: upg_wen_o rises exactly 1 cycle after byte_valid of the 4th byte.
//  Boundaries:
//   - word_index never wraps past 16383, because of the clamp.
//   - Bytes beyond a clamped count are parsed in IDLE; err is set only if a byte is not
//     a valid command.
//   - A framing error inside DATA drops that byte only. Lanes stay aligned to received
//     bytes, so the host must retransmit the session.
//   - reset mid-frame: FSM=IDLE, receiver idle, partial word discarded, done/err cleared.
//   - byte_valid and reset in the same cycle: reset wins.
// STRUCTURE
//  Shared package (loader_pkg):
//   - CMD_IMEM=8'h49, CMD_DMEM=8'h44, CMD_END=8'h45
//   - state encoding localparams
//   - ADR_W=15
//  Sub-module uart_rx (CLKS_PER_BIT): clock, reset, rx -> byte_valid, byte_data[7:0], frame_err.
//  Top level holds the framing FSM, the byte/word counters and the output registers.
// TESTING
//  1. Send 'I',0x02,0x00, then 78 56 34 12 EF BE AD DE
//     -> two strobes: adr 0x0000 dat 0x12345678, then adr 0x0001 dat 0xDEADBEEF.
//  2. Send 'D',0x01,0x00, then 01 00 00 00 -> one strobe: adr 0x4000 dat 0x00000001.
//     Then send 'E' -> upg_done_o=1. A later 'I' frame produces no strobe.
//  3. Send 0x7A -> upg_err_o=1, FSM stays in IDLE. A valid 'I' frame after it still writes.
//  4. Send a byte with stop bit=0 during DATA -> upg_err_o=1, no strobe for that byte.
//  5. Assert reset after 2 data bytes. Then send 'I',1,0, AA BB CC DD
//     -> adr 0x0000 dat 0xDDCCBBAA, err=0.
//  6. Put a 0.3-bit low glitch on upg_rx_i -> no byte_valid, no err. Also send 'I',0,0
//     -> back to IDLE with no strobe.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and state types for the serial program loader
// Purpose: command bytes, address width, loader/receiver state encodings, count clamp helper.
// Ports: none (package).
package loader_pkg;

    localparam logic [7:0] CMD_IMEM = 8'h49;
    localparam logic [7:0] CMD_DMEM = 8'h44;
    localparam logic [7:0] CMD_END  = 8'h45;

    localparam int ADR_W = 15;
    localparam int IDX_W = 14;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CNT_LO = 3'd1;
    localparam logic [2:0] ST_CNT_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_CNT_LO = ST_CNT_LO,
        S_CNT_HI = ST_CNT_HI,
        S_DATA   = ST_DATA,
        S_DONE   = ST_DONE
    } ldr_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    // Word count from the frame header, limited so the 14-bit word index never wraps.
    function automatic logic [14:0] clamp_count(input logic [15:0] cnt, input int max_words);
        if (int'(cnt) > max_words) begin
            return 15'(max_words);
        end
        return cnt[14:0];
    endfunction

endpackage

// File: rtl/uart_loader_if.sv
// rtl/uart_loader_if.sv - serial input and upg write-port bundle of the loader
// Purpose: groups the serial line and the upg_* write/status signals.
// Ports: upg_rx_i (serial in), upg_wen_o, upg_adr_o[14:0], upg_dat_o[31:0], upg_done_o, upg_err_o.
// master = loader side, slave = host/memory side.
interface uart_loader_if;
    import loader_pkg::*;

    logic             upg_rx_i;
    logic             upg_wen_o;
    logic [ADR_W-1:0] upg_adr_o;
    logic [31:0]      upg_dat_o;
    logic             upg_done_o;
    logic             upg_err_o;

    modport master (
        input  upg_rx_i,
        output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o
    );

    modport slave (
        output upg_rx_i,
        input  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o
    );

endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 byte receiver with start-glitch rejection and framing check
// Purpose: synchronizes rx, samples bits at their centres, reports bytes or framing errors.
// Ports: clock, reset (sync, active-high), rx (async serial in),
//        byte_valid (1-cycle pulse), byte_data[7:0], frame_err (1-cycle pulse).
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 86
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    rx_state_t   r_state;
    logic [1:0]  r_sync;
    logic        r_rx_d;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_valid;
    logic [7:0]  r_data;
    logic        r_ferr;

    logic w_rx;
    logic w_fall;

    assign w_rx   = r_sync[1];
    assign w_fall = r_rx_d & ~w_rx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RX_IDLE;
            r_sync  <= 2'b11;
            r_rx_d  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_rx_d  <= w_rx;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= '0;
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Half a bit after the edge: still low means a real start bit.
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                        r_bit <= r_bit + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_valid <= 1'b1;
                            r_data  <= r_shift;
                            r_state <= RX_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= RX_WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_WAIT: begin
                    // Broken frame: resynchronize only once the line returns to idle.
                    if (w_rx) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid = r_valid;
    assign byte_data  = r_data;
    assign frame_err  = r_ferr;

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - serial program loader driving the upg write port
// Purpose: parses I/D load frames and the E end byte, assembles little-endian words,
//          strobes them to instruction ROM (adr[14]=0) or data RAM (adr[14]=1).
// Ports: clock, reset (sync, active-high), upg (uart_loader_if.master):
//        upg_rx_i in, upg_wen_o/upg_adr_o/upg_dat_o/upg_done_o/upg_err_o out.
module uart_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ    = 10_000_000,
    parameter int BAUD      = 115_200,
    parameter int MAX_WORDS = 16384
) (
    input  logic           clock,
    input  logic           reset,
    uart_loader_if.master  upg
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (upg.upg_rx_i),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .frame_err  (w_frame_err)
    );

    ldr_state_t       r_state;
    logic             r_target;
    logic [7:0]       r_cnt_lo;
    logic [14:0]      r_remaining;
    logic [1:0]       r_byte_idx;
    logic [IDX_W-1:0] r_word_idx;
    logic [31:0]      r_word;
    logic             r_wen;
    logic [ADR_W-1:0] r_adr;
    logic [31:0]      r_dat;
    logic             r_done;
    logic             r_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_target    <= 1'b0;
            r_cnt_lo    <= '0;
            r_remaining <= '0;
            r_byte_idx  <= '0;
            r_word_idx  <= '0;
            r_word      <= '0;
            r_wen       <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            if (w_frame_err) begin
                r_err <= 1'b1;
            end
            if (w_byte_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_byte_data == CMD_IMEM || w_byte_data == CMD_DMEM) begin
                            r_target <= (w_byte_data == CMD_DMEM);
                            r_state  <= S_CNT_LO;
                        end else if (w_byte_data == CMD_END) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    S_CNT_LO: begin
                        r_cnt_lo <= w_byte_data;
                        r_state  <= S_CNT_HI;
                    end
                    S_CNT_HI: begin
                        if ({w_byte_data, r_cnt_lo} == 16'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_remaining <= clamp_count({w_byte_data, r_cnt_lo}, MAX_WORDS);
                            r_byte_idx  <= '0;
                            r_word_idx  <= '0;
                            r_state     <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            // Last lane goes straight into the output word, strobe next cycle.
                            r_wen       <= 1'b1;
                            r_dat       <= {w_byte_data, r_word[23:0]};
                            r_adr       <= {r_target, r_word_idx};
                            r_word_idx  <= r_word_idx + 14'd1;
                            r_remaining <= r_remaining - 15'd1;
                            if (r_remaining == 15'd1) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_word[8*r_byte_idx +: 8] <= w_byte_data;
                        end
                    end
                    S_DONE: begin
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign upg.upg_wen_o  = r_wen;
    assign upg.upg_adr_o  = r_adr;
    assign upg.upg_dat_o  = r_dat;
    assign upg.upg_done_o = r_done;
    assign upg.upg_err_o  = r_err;

endmodule
